scc_run_ctrl: RTL and testbench

- Synthesizable run controller that sequences a multi-core SCC test run.
- Holds the cores in reset for a programmable number of cycles, gates their clock enable, and counts run cycles.
- Detects completion when all cores halt, or on watchdog timeout or abort, and latches a final status and the error bits for inspection.
- Sits between the bench/host and one or more scc_f25_top instances, replacing hand-coded reset/run sequencing.

---
 rtl/scc_run_ctrl_pkg.sv | 34 +++
 rtl/scc_run_ctrl_sat_counter.sv | 44 ++++
 rtl/scc_run_ctrl.sv | 149 ++++++++++++++
 tb/tb_scc_run_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scc_run_ctrl_pkg.sv
// ============================================================================
// Module : scc_run_defs (package)
// Brief  : Shared state encoding, status codes and counter opcodes for the
//          SCC run controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scc_run_defs;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } run_state_t;

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_ERR     = 3'd2;
    localparam logic [2:0] ST_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_ABORT   = 3'd4;

    typedef enum logic [2:0] {
        CNT_HOLD  = 3'd0,
        CNT_LOAD  = 3'd1,
        CNT_DEC   = 3'd2,
        CNT_INC   = 3'd3,
        CNT_CLEAR = 3'd4
    } cnt_op_t;

endpackage

`default_nettype wire

// File: rtl/scc_run_ctrl_sat_counter.sv
// ============================================================================
// Module : scc_sat_counter
// Brief  : Parametrised counter with load / decrement / increment / clear.
//          Increment sticks at all-ones, decrement sticks at zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scc_sat_counter
    import scc_run_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case (cnt_op_t'(op))
                CNT_LOAD:  r_count <= load_val;
                CNT_DEC:   if (r_count != '0)         r_count <= r_count - c_ONE;
                CNT_INC:   if (r_count != c_ALL_ONES) r_count <= r_count + c_ONE;
                CNT_CLEAR: r_count <= '0;
                default:   r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/scc_run_ctrl.sv
// ============================================================================
// Module : scc_run_ctrl
// Brief  : Sequences a multi-core SCC run: reset hold, clock-enabled run with
//          watchdog, completion detection and latched final status.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scc_run_ctrl
    import scc_run_defs::*;
#(
    parameter int NUM_CORES       = 1,
    parameter int RST_HOLD_CYCLES = 3,
    parameter int MAX_RUN_CYCLES  = 30,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_CORES-1:0]   core_halt_f,
    input  logic [2*NUM_CORES-1:0] core_err_bits,
    output logic                   core_rst,
    output logic                   core_clk_en,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             status,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [2*NUM_CORES-1:0] err_capture
);

    localparam int                  c_HOLD_W     = $clog2(RST_HOLD_CYCLES) + 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD  = c_HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_TIMEOUT_AT = CNT_W'(MAX_RUN_CYCLES - 1);
    localparam bit                  c_WDOG_EN    = (MAX_RUN_CYCLES != 0);

    run_state_t             r_state;
    run_state_t             w_state_nxt;
    logic [2:0]             r_status;
    logic [2:0]             w_status_nxt;
    logic [2*NUM_CORES-1:0] r_err;
    logic [2*NUM_CORES-1:0] w_err_nxt;
    logic [2*NUM_CORES-1:0] w_err_merged;
    logic [2:0]             w_hold_op;
    logic [2:0]             w_cyc_op;
    logic [c_HOLD_W-1:0]    w_hold_cnt;
    logic [CNT_W-1:0]       w_cycle_cnt;
    logic                   w_all_halted;
    logic                   w_timeout;

    scc_sat_counter #(
        .WIDTH (c_HOLD_W)
    ) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .op       (w_hold_op),
        .load_val (c_HOLD_LOAD),
        .count    (w_hold_cnt)
    );

    scc_sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clk      (clk),
        .rst      (rst),
        .op       (w_cyc_op),
        .load_val ('0),
        .count    (w_cycle_cnt)
    );

    // The exit cycle's own error bits count towards PASS/ERR.
    assign w_err_merged = r_err | core_err_bits;
    assign w_all_halted = &core_halt_f;
    assign w_timeout    = c_WDOG_EN && (w_cycle_cnt == c_TIMEOUT_AT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_status <= ST_NONE;
            r_err    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_err_nxt    = r_err;
        w_hold_op    = CNT_HOLD;
        w_cyc_op     = CNT_HOLD;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt  = S_RESET;
                    w_status_nxt = ST_NONE;
                    w_err_nxt    = '0;
                    w_hold_op    = CNT_LOAD;
                    w_cyc_op     = CNT_CLEAR;
                end
            end

            S_RESET: begin
                if (abort) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_ABORT;
                end else if (w_hold_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_hold_op = CNT_DEC;
                end
            end

            S_RUN: begin
                w_cyc_op  = CNT_INC;
                w_err_nxt = w_err_merged;
                if (abort) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_ABORT;
                end else if (w_all_halted) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = (w_err_merged == '0) ? ST_PASS : ST_ERR;
                end else if (w_timeout) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_TIMEOUT;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from flops so no input reaches an output.
    assign core_rst    = (r_state == S_IDLE) || (r_state == S_RESET);
    assign core_clk_en = (r_state == S_RESET) || (r_state == S_RUN);
    assign busy        = (r_state == S_RESET) || (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign status      = r_status;
    assign cycle_count = w_cycle_cnt;
    assign err_capture = r_err;

endmodule

`default_nettype wire

// File: tb/tb_scc_run_ctrl.sv
// ============================================================================
// Module : tb_scc_run_ctrl
// Brief  : Randomised self-checking bench for scc_run_ctrl with an outcome
//          model computed per run from the scheduled stimulus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scc_run_ctrl;
    import scc_run_defs::*;

    localparam int HOLD = 3;
    localparam int MAXR = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [1:0]  halt;
    logic [3:0]  errb;
    logic        core_rst, core_clk_en, busy, done;
    logic [2:0]  status;
    logic [15:0] cycle_count;
    logic [3:0]  err_capture;

    logic        s_start, s_abort;
    logic [1:0]  s_halt;
    logic [3:0]  s_errb;
    logic        s_core_rst, s_clk_en, s_busy, s_done;
    logic [2:0]  s_status;
    logic [3:0]  s_count;
    logic [3:0]  s_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scc_run_ctrl #(
        .NUM_CORES       (2),
        .RST_HOLD_CYCLES (HOLD),
        .MAX_RUN_CYCLES  (MAXR),
        .CNT_W           (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .core_halt_f   (halt),
        .core_err_bits (errb),
        .core_rst      (core_rst),
        .core_clk_en   (core_clk_en),
        .busy          (busy),
        .done          (done),
        .status        (status),
        .cycle_count   (cycle_count),
        .err_capture   (err_capture)
    );

    scc_run_ctrl #(
        .NUM_CORES       (2),
        .RST_HOLD_CYCLES (HOLD),
        .MAX_RUN_CYCLES  (0),
        .CNT_W           (4)
    ) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .start         (s_start),
        .abort         (s_abort),
        .core_halt_f   (s_halt),
        .core_err_bits (s_errb),
        .core_rst      (s_core_rst),
        .core_clk_en   (s_clk_en),
        .busy          (s_busy),
        .done          (s_done),
        .status        (s_status),
        .cycle_count   (s_count),
        .err_capture   (s_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One run from a start pulse. ra: abort in RESET cycle ra; a: abort in
    // RUN cycle a; h: RUN cycle where all cores are halted (0 = never).
    // err_mode 0: no errors, 1: random error bits, 2: core0 pulse at RUN cycle 4.
    task automatic run_scenario(input int ra, input int a, input int h,
                                input int err_mode, input bit junk);
        int         run_end;
        int         busy_len;
        int         exp_cnt;
        int         rst_len;
        logic [2:0] exp_st;
        logic [3:0] exp_err;

        exp_err = 4'h0;
        if (ra != 0) begin
            run_end  = 0;
            busy_len = ra;
            exp_cnt  = 0;
        end else begin
            run_end = MAXR;
            if (h != 0 && h < run_end) run_end = h;
            if (a != 0 && a < run_end) run_end = a;
            busy_len = HOLD + run_end;
            exp_cnt  = run_end;
        end
        rst_len = (busy_len < HOLD) ? busy_len : HOLD;

        start = 1'b1;
        abort = 1'($urandom_range(0, 1));
        halt  = 2'b00;
        errb  = 4'h0;

        for (int j = 1; j <= busy_len + 2; j++) begin
            @(negedge clk);
            check("busy", busy, j <= busy_len);
            check("core_rst", core_rst, j <= rst_len);
            check("clk_en", core_clk_en, j <= busy_len);
            check("done", done, j > busy_len);
            if (j > HOLD && j <= busy_len)
                check("run_count", cycle_count, j - HOLD - 1);

            start = junk && (j <= busy_len) && ($urandom_range(0, 3) == 0);
            abort = (ra != 0 && j == ra) || (ra == 0 && a != 0 && j == HOLD + a) ||
                    (j > busy_len && $urandom_range(0, 1) == 1);
            if (h != 0 && j >= HOLD + h) halt = 2'b11;
            else                         halt = {1'($urandom_range(0, 1)), 1'b0};
            case (err_mode)
                1:       errb = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
                2:       errb = (j == HOLD + 4) ? 4'b0001 : 4'h0;
                default: errb = 4'h0;
            endcase
            if (ra == 0 && j > HOLD && j <= busy_len) exp_err = exp_err | errb;
        end

        if (ra != 0)                       exp_st = ST_ABORT;
        else if (a != 0 && a == run_end)   exp_st = ST_ABORT;
        else if (h != 0 && h == run_end)   exp_st = (exp_err == 4'h0) ? ST_PASS : ST_ERR;
        else                               exp_st = ST_TIMEOUT;

        check("status", status, exp_st);
        check("final_count", cycle_count, exp_cnt);
        check("err_capture", err_capture, exp_err);
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int ra_r, a_r, h_r;

        rst = 1'b0;
        start = 1'b0; abort = 1'b0; halt = 2'b00; errb = 4'h0;
        s_start = 1'b0; s_abort = 1'b0; s_halt = 2'b01; s_errb = 4'h0;

        repeat (3) @(negedge clk);
        check("rst_core_rst", core_rst, 1);
        check("rst_clk_en", core_clk_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status", status, ST_NONE);
        check("rst_count", cycle_count, 0);
        check("rst_err", err_capture, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_core_rst", core_rst, 1);
        check("idle_busy", busy, 0);

        run_scenario(0, 0, 10, 0, 1'b0);
        run_scenario(0, 0, 12, 2, 1'b0);
        run_scenario(0, 0, 0, 0, 1'b0);
        run_scenario(2, 0, 0, 1, 1'b0);
        run_scenario(0, 7, 7, 0, 1'b0);
        run_scenario(0, 15, 0, 1, 1'b1);

        // Asynchronous reset landing between edges in the middle of RUN.
        start = 1'b1;
        repeat (HOLD + 6) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_arst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_core_rst", core_rst, 1);
        check("arst_busy", busy, 0);
        check("arst_status", status, ST_NONE);
        check("arst_count", cycle_count, 0);
        check("arst_clk_en", core_clk_en, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_arst_core_rst", core_rst, 1);
        check("post_arst_done", done, 0);

        run_scenario(0, 0, 5, 1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            ra_r = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, HOLD)) : 0;
            a_r  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 35)) : 0;
            h_r  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 35));
            run_scenario(ra_r, a_r, h_r, 1, 1'b1);
        end

        // Watchdog disabled, 4-bit counter: run stays busy and the count sticks at 15.
        s_start = 1'b1;
        for (int j = 1; j <= 110; j++) begin
            @(negedge clk);
            check("sat_busy", s_busy, 1);
            if (j > HOLD)
                check("sat_count", s_count, ((j - HOLD - 1) > 15) ? 15 : (j - HOLD - 1));
            s_start = 1'b0;
            s_abort = (j == 110);
        end
        @(negedge clk);
        s_abort = 1'b0;
        check("sat_done", s_done, 1);
        check("sat_status", s_status, ST_ABORT);
        check("sat_final_count", s_count, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
